// File: rtl/reg_dump_reader_if.sv
// Byte stream with valid/ready handshake; out_last marks the final byte of a dump.
interface reg_dump_reader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file through one read port and streams every word MSB byte first,
// followed by an XOR checksum byte flagged with out_last.
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    reg_dump_reader_if.master out_if,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic              out_valid;
    logic              hs;

    assign hs = out_valid && out_if.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                csum_d = '0;
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                // Snapshot at the closing edge: a write landing on this same edge is not seen.
                rd_addr_d  = cnt_q;
                shift_d    = rd_data_i;
                byte_idx_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (hs) begin
                    csum_d     = csum_q ^ shift_q[DATA_W-1 -: 8];
                    shift_d    = {shift_q[DATA_W-9:0], 8'h00};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (cnt_q == LAST_REG) begin
                            state_d = CSUM;
                        end else begin
                            cnt_d   = cnt_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            CSUM:    if (hs) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid       = (state_q == SEND) || (state_q == CSUM);
        out_if.out_last = (state_q == CSUM);
        out_if.out_data = 8'h00;
        if (state_q == SEND) out_if.out_data = shift_q[DATA_W-1 -: 8];
        if (state_q == CSUM) out_if.out_data = csum_q;
        out_if.out_valid = out_valid;
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == DONE);
        rd_addr_o = (state_q == FETCH) ? cnt_q : rd_addr_q;
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: reset, full dumps, backpressure, start filtering, write race.
module tb_reg_dump_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy, done;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] mem [32];
    logic [31:0] shadow [32];

    reg_dump_reader_if bus ();

    reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .out_if(bus.master), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (we) mem[wa] <= wd;
    assign rd_data = mem[rd_addr];

    int nchk = 0;
    int nerr = 0;

    logic [7:0] byte_q [$];
    int n_hs, last_cnt, last_idx, last_cyc, done_cyc, done_cnt, stable_err;
    logic [7:0] csum_seen;
    logic idle_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
        shadow[a] = d;
    endtask

    function automatic int count_bad();
        int bad = 0;
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++) begin
                logic [31:0] w;
                int i;
                w = shadow[r];
                i = r * 4 + b;
                if (i >= byte_q.size() || byte_q[i] !== w[31 - 8*b -: 8]) bad++;
            end
        return bad;
    endfunction

    // Cycle c of the loop is cycle c after the start edge; the bound covers heavy backpressure.
    task automatic run_dump(input bit rnd, input bit skip_start, input int s1, input int s2,
                            input int wcyc, input logic [31:0] wval, input bit chain);
        logic [7:0] prev_d;
        logic prev_l, prev_stall;
        byte_q.delete();
        n_hs = 0; last_cnt = 0; last_idx = -1; last_cyc = -1;
        done_cyc = -1; done_cnt = 0; stable_err = 0; csum_seen = 8'hxx; idle_after = 1'b0;
        prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            start = (c == s1) || (c == s2);
            we = (c == wcyc); wa = 5'd5; wd = wval;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_d || bus.out_last !== prev_l))
                stable_err++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d = bus.out_data; prev_l = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                byte_q.push_back(bus.out_data);
                n_hs++;
                if (bus.out_last) begin
                    last_cnt++; last_idx = n_hs - 1; last_cyc = c; csum_seen = bus.out_data;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                idle_after = !busy;
                if (chain) start = 1'b1;
                break;
            end
        end
        if (!chain) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; wa = '0; wd = '0; bus.out_ready = 1'b1;
        for (int i = 0; i < 31; i++) wr(5'(i), 32'(i));
        wr(5'd31, 32'hDEADBEEF);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_last",  32'(bus.out_last),  0);
        chk("rst_data",  32'(bus.out_data),  0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_addr",  32'(rd_addr), 0);
        rst = 1'b0;

        // Reset mid-stream: stall in SEND, then reset.
        @(negedge clk); start = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("fetch_busy", 32'(busy), 1);
        @(negedge clk);
        chk("send_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_valid", 32'(bus.out_valid), 0);
        chk("mrst_busy",  32'(busy), 0);
        chk("mrst_data",  32'(bus.out_data), 0);
        chk("mrst_addr",  32'(rd_addr), 0);
        @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1;
        begin
            int dn = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || busy) dn++;
            end
            chk("mrst_no_done", 32'(dn), 0);
        end

        // Full dump with ready held high; chain a start into the first IDLE cycle.
        run_dump(1'b0, 1'b0, -1, -1, -1, 32'h0, 1'b1);
        chk("full_hs",       32'(n_hs), 129);
        chk("full_bytes",    32'(count_bad()), 0);
        chk("full_b123",     32'(byte_q[123]), 32'h1E);
        chk("full_reg31",    {byte_q[124], byte_q[125], byte_q[126], byte_q[127]}, 32'hDEADBEEF);
        chk("full_csum",     32'(csum_seen), 32'h3D);
        chk("full_last_cnt", 32'(last_cnt), 1);
        chk("full_last_cyc", 32'(last_cyc), 161);
        chk("full_done_cyc", 32'(done_cyc), 162);
        chk("full_idle",     32'(idle_after), 1);

        // Chained dump; starts at cycles 10 and 100 must be ignored.
        run_dump(1'b0, 1'b1, 10, 100, -1, 32'h0, 1'b0);
        chk("ign_done_cnt", 32'(done_cnt), 1);
        chk("ign_done_cyc", 32'(done_cyc), 162);
        chk("ign_hs",       32'(n_hs), 129);
        chk("ign_csum",     32'(csum_seen), 32'h3D);
        repeat (5) @(negedge clk);
        chk("ign_no_restart", 32'(busy), 0);

        // Random backpressure.
        run_dump(1'b1, 1'b0, -1, -1, -1, 32'h0, 1'b0);
        chk("bp_hs",     32'(n_hs), 129);
        chk("bp_bytes",  32'(count_bad()), 0);
        chk("bp_csum",   32'(csum_seen), 32'h3D);
        chk("bp_stable", 32'(stable_err), 0);
        chk("bp_last",   32'(last_idx), 128);
        bus.out_ready = 1'b1;

        // Write race on register 5 (FETCH 5 is cycle 26).
        run_dump(1'b0, 1'b0, -1, -1, 26, 32'h12345678, 1'b0);
        chk("race_same", {byte_q[20], byte_q[21], byte_q[22], byte_q[23]}, 32'h5);
        wr(5'd5, 32'h5);
        run_dump(1'b0, 1'b0, -1, -1, 25, 32'h12345678, 1'b0);
        chk("race_early", {byte_q[20], byte_q[21], byte_q[22], byte_q[23]}, 32'h12345678);

        // All-zero register file.
        for (int i = 0; i < 32; i++) wr(5'(i), 32'h0);
        run_dump(1'b0, 1'b0, -1, -1, -1, 32'h0, 1'b0);
        chk("zero_hs",    32'(n_hs), 129);
        chk("zero_bytes", 32'(count_bad()), 0);
        chk("zero_csum",  32'(csum_seen), 32'h00);
        chk("zero_last",  32'(last_idx), 128);
        chk("zero_lcnt",  32'(last_cnt), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
